// File: rtl/lzc_norm_pkg.sv
// lzc_norm_pkg: shared sizing helpers and payload layouts for the
// leading-zero count / normalise pipeline. Default sizes (32-bit operand,
// 4-bit tag) match the SRT divider datapath.
// Optional feature macro: LZC_NORM_SIGNED_EN (see lzc_norm_pipe.sv).
`timescale 1ns/1ps
package lzc_norm_pkg;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int LZC_WIDTH = 32;
    localparam int LZC_TAG_W = 4;
    localparam int LZC_CNT_W = clog2(LZC_WIDTH);

    // S1 payload: operand, tag, counting mode and the count from the tree.
    typedef struct packed {
        logic [LZC_WIDTH-1:0] data;
        logic [LZC_TAG_W-1:0] tag;
        logic                 sgn;
        logic [LZC_CNT_W-1:0] cnt;
    } s1_pay_t;

    // S2 payload: everything the consumer sees on out_*.
    typedef struct packed {
        logic [LZC_WIDTH-1:0] norm;
        logic [LZC_CNT_W-1:0] cnt;
        logic                 zero;
        logic [LZC_TAG_W-1:0] tag;
    } s2_pay_t;

endpackage

// File: rtl/lzc_norm_pipe_if.sv
// lzc_norm_pipe_if: operand-in / result-out handshake bundle.
// Both sides use valid/ready: a transfer happens on a rising clock edge
// where valid and ready are both high; a producer holds valid and its
// payload stable until that transfer.
// in_signed is only honoured when LZC_NORM_SIGNED_EN is defined.
`timescale 1ns/1ps
interface lzc_norm_pipe_if
    import lzc_norm_pkg::*;
#(
    parameter int WIDTH = LZC_WIDTH,
    parameter int TAG_W = LZC_TAG_W
);
    localparam int CNT_W = clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_signed;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_cnt;
    logic [WIDTH-1:0] out_norm;
    logic             out_zero;
    logic [TAG_W-1:0] out_tag;

    // Producer of operands / consumer of results.
    modport master (
        output in_valid, in_data, in_signed, in_tag, out_ready,
        input  in_ready, out_valid, out_cnt, out_norm, out_zero, out_tag
    );

    // The normaliser pipeline itself.
    modport slave (
        input  in_valid, in_data, in_signed, in_tag, out_ready,
        output in_ready, out_valid, out_cnt, out_norm, out_zero, out_tag
    );

endinterface

// File: rtl/lzc_tree.sv
// lzc_tree: purely combinational leading-zero counter built as a recursive
// binary tree. Each node picks the low half's count (with the MSB set) when
// the high half is empty, otherwise the high half's count. An all-zero input
// yields cnt = WIDTH-1 and zero = 1. WIDTH must be a power of two >= 2.
`timescale 1ns/1ps
module lzc_tree
    import lzc_norm_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] in_data,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    if (WIDTH == 2) begin : g_leaf
        // Two-bit leaf: count is 1 exactly when the upper bit is clear.
        assign zero = ~|in_data;
        assign cnt  = ~in_data[1];
    end else begin : g_node
        logic [CNT_W-2:0] cnt_hi;
        logic [CNT_W-2:0] cnt_lo;
        logic             zero_hi;
        logic             zero_lo;

        lzc_tree #(.WIDTH(WIDTH / 2)) u_hi (
            .in_data (in_data[WIDTH-1:WIDTH/2]),
            .cnt     (cnt_hi),
            .zero    (zero_hi)
        );

        lzc_tree #(.WIDTH(WIDTH / 2)) u_lo (
            .in_data (in_data[WIDTH/2-1:0]),
            .cnt     (cnt_lo),
            .zero    (zero_lo)
        );

        // Merge the two halves.
        assign zero = zero_hi & zero_lo;
        assign cnt  = zero_hi ? {1'b1, cnt_lo} : {1'b0, cnt_hi};
    end

endmodule

// File: rtl/lzc_norm_pipe.sv
// lzc_norm_pipe: two-stage leading-zero count and normalise.
// S1 registers operand, tag, mode and count (count tree ahead of S1);
// S2 registers the barrel-shifted operand, count, zero flag and tag.
// Skid-free elastic pipeline: S2 loads when empty or drained, S1 loads when
// empty or S2 loads, so a full pipe still moves one operand per cycle.
// flush kills both stages on the next edge and blocks acceptance this cycle.
// Macro LZC_NORM_SIGNED_EN: when defined, in_signed selects counting of
// redundant sign bits per operand; when undefined in_signed is ignored.
`timescale 1ns/1ps
module lzc_norm_pipe
    import lzc_norm_pkg::*;
#(
    parameter int WIDTH = LZC_WIDTH,
    parameter int TAG_W = LZC_TAG_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    lzc_norm_pipe_if.slave bus
);

    localparam int CNT_W = clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [TAG_W-1:0] tag;
`ifdef LZC_NORM_SIGNED_EN
        logic             sgn;
`endif
        logic [CNT_W-1:0] cnt;
    } s1_t;

    typedef struct packed {
        logic [WIDTH-1:0] norm;
        logic [CNT_W-1:0] cnt;
        logic             zero;
        logic [TAG_W-1:0] tag;
    } s2_t;

    logic             s1_valid_q, s1_valid_d;
    logic             s2_valid_q, s2_valid_d;
    s1_t              s1_q, s1_d;
    s2_t              s2_q, s2_d;

    logic             s2_load;
    logic             s1_load;
    logic             accept;
    logic [WIDTH-1:0] tree_in;
    logic [CNT_W-1:0] tree_cnt;
    logic             tree_zero;
    logic [CNT_W-1:0] cnt_in;
    logic             s1_zero;

`ifndef LZC_NORM_SIGNED_EN
    logic             unused_in_signed;
    assign unused_in_signed = bus.in_signed;
`endif

    // Tree operand: signed mode turns the sign-bit run into a zero run and
    // drops the sign bit itself, so the tree count is already run-length - 1.
    always_comb begin
        tree_in = bus.in_data;
`ifdef LZC_NORM_SIGNED_EN
        if (bus.in_signed) begin
            tree_in = (bus.in_data ^ {WIDTH{bus.in_data[WIDTH-1]}}) << 1;
        end
`endif
    end

    lzc_tree #(.WIDTH(WIDTH)) u_tree (
        .in_data (tree_in),
        .cnt     (tree_cnt),
        .zero    (tree_zero)
    );

    // Pin the degenerate count explicitly rather than relying on the tree's
    // empty-path encoding.
    assign cnt_in = tree_zero ? CNT_MAX : tree_cnt;

    // Handshake: S2 frees up when empty or drained; S1 when empty or moving.
    assign s2_load      = !s2_valid_q || bus.out_ready;
    assign s1_load      = !s1_valid_q || s2_load;
    assign bus.in_ready = s1_load && !flush;
    assign accept       = bus.in_valid && bus.in_ready;

    // Zero flag is derived from the registered operand in S2's input cone.
    always_comb begin
        s1_zero = (s1_q.data == '0);
`ifdef LZC_NORM_SIGNED_EN
        if (s1_q.sgn) begin
            s1_zero = (s1_q.data == {WIDTH{s1_q.data[WIDTH-1]}});
        end
`endif
    end

    // Next-state for both stages; data registers only move on a load.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        s1_d       = s1_q;
        s2_d       = s2_q;
        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (s2_load) begin
                s2_valid_d = s1_valid_q;
                if (s1_valid_q) begin
                    s2_d.norm = s1_q.data << s1_q.cnt;
                    s2_d.cnt  = s1_q.cnt;
                    s2_d.zero = s1_zero;
                    s2_d.tag  = s1_q.tag;
                end
            end
            if (s1_load) begin
                s1_valid_d = accept;
                if (accept) begin
                    s1_d.data = bus.in_data;
                    s1_d.tag  = bus.in_tag;
`ifdef LZC_NORM_SIGNED_EN
                    s1_d.sgn  = bus.in_signed;
`endif
                    s1_d.cnt  = cnt_in;
                end
            end
        end
    end

    // Pipeline registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_q       <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
        end
    end

    assign bus.out_valid = s2_valid_q;
    assign bus.out_cnt   = s2_q.cnt;
    assign bus.out_norm  = s2_q.norm;
    assign bus.out_zero  = s2_q.zero;
    assign bus.out_tag   = s2_q.tag;

endmodule
